icache_refill_ctrl: RTL

Sequencing controller that sits between the fetch stage and the instruction cache/memory pair. It accepts fetch requests, performs a cache lookup, and on a miss runs a refill transaction: a memory read, a cache line write, then the instruction handed back to fetch. It owns the `busy` stall signal that the fetch stage previously left unimplemented, and it counts misses for performance debug.

---
 rtl/icache_refill_ctrl_pkg.sv | 18 +
 rtl/icache_refill_ctrl_if.sv | 26 ++
 rtl/icache_refill_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/icache_refill_ctrl_pkg.sv
// Shared constants and state encoding for the instruction-cache refill controller.
// Stands in for the old parameters.v: word size, timeout default, FSM states.
package icache_refill_ctrl_pkg;

    localparam int unsigned WORD_SIZE_DEF   = 16;
    localparam int unsigned MEM_TIMEOUT_DEF = 64;
    localparam int unsigned MISS_CNT_W_DEF  = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        CHECK,
        MEM_WAIT,
        FILL,
        RESP
    } state_t;

endpackage

// File: rtl/icache_refill_ctrl_if.sv
// Cache lookup/fill and memory read signals between the refill controller and the
// cache/memory pair. master = controller side, slave = cache/memory side.
interface icache_refill_ctrl_if #(
    parameter int unsigned W = 16
);
    logic         cache_enable;
    logic [W-1:0] cache_addr;
    logic         hit;
    logic [W-1:0] cache_inst;
    logic         fill_en;
    logic [W-1:0] fill_data;
    logic         mem_req;
    logic [W-1:0] mem_addr;
    logic         mem_ack;
    logic [W-1:0] mem_data;

    modport master (
        output cache_enable, cache_addr, fill_en, fill_data, mem_req, mem_addr,
        input  hit, cache_inst, mem_ack, mem_data
    );

    modport slave (
        input  cache_enable, cache_addr, fill_en, fill_data, mem_req, mem_addr,
        output hit, cache_inst, mem_ack, mem_data
    );
endinterface

// File: rtl/icache_refill_ctrl.sv
// Fetch-side refill sequencer: lookup, miss refill from memory, cache fill, deliver.
// Optional memory watchdog enabled by defining ICACHE_REFILL_TIMEOUT_EN.
module icache_refill_ctrl
    import icache_refill_ctrl_pkg::*;
#(
    parameter int unsigned WORD_SIZE   = WORD_SIZE_DEF,
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int unsigned MISS_CNT_W  = MISS_CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_enable,
    input  logic [WORD_SIZE-1:0]  ptr,
    icache_refill_ctrl_if.master  bus,
    output logic [WORD_SIZE-1:0]  out,
    output logic                  inst_valid,
    output logic                  busy,
    output logic [MISS_CNT_W-1:0] miss_count,
    output logic                  mem_err
);

    state_t               state, state_n;
    logic [WORD_SIZE-1:0] addr_q, data_q;
    logic                 cache_enable_c, fill_en_c, mem_req_c;
    logic                 tmo_fire;

    assign bus.cache_enable = cache_enable_c;
    assign bus.fill_en      = fill_en_c;
    assign bus.mem_req      = mem_req_c;
    assign bus.cache_addr   = addr_q;
    assign bus.mem_addr     = addr_q;
    assign bus.fill_data    = data_q;

`ifdef ICACHE_REFILL_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(MEM_TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             mem_err_q;

    // Fires on the MEM_TIMEOUT-th MEM_WAIT cycle; a same-cycle ack still wins.
    assign tmo_fire = (state == MEM_WAIT) && !bus.mem_ack &&
                      (tmo_cnt == TMO_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_cnt   <= '0;
            mem_err_q <= 1'b0;
        end else begin
            if (state == MEM_WAIT && !bus.mem_ack)
                tmo_cnt <= tmo_cnt + 1'b1;
            else
                tmo_cnt <= '0;
            if (tmo_fire)
                mem_err_q <= 1'b1;
        end
    end

    assign mem_err = mem_err_q;
`else
    assign tmo_fire = 1'b0;
    assign mem_err  = 1'b0;
`endif

    always_comb begin
        state_n        = state;
        cache_enable_c = 1'b0;
        fill_en_c      = 1'b0;
        mem_req_c      = 1'b0;
        unique case (state)
            IDLE:     if (fetch_enable) state_n = LOOKUP;
            LOOKUP: begin
                cache_enable_c = 1'b1;
                state_n        = CHECK;
            end
            CHECK:    state_n = bus.hit ? IDLE : MEM_WAIT;
            MEM_WAIT: begin
                mem_req_c = 1'b1;
                if (bus.mem_ack)
                    state_n = FILL;
                else if (tmo_fire)
                    state_n = IDLE;
            end
            FILL: begin
                fill_en_c = 1'b1;
                state_n   = RESP;
            end
            RESP:     state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            out        <= '0;
            inst_valid <= 1'b0;
            miss_count <= '0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state      <= state_n;
            busy       <= (state_n != IDLE);
            inst_valid <= 1'b0;

            if (state == IDLE && fetch_enable)
                addr_q <= ptr;
            if (state == MEM_WAIT && bus.mem_ack)
                data_q <= bus.mem_data;

            if (state == CHECK) begin
                if (bus.hit) begin
                    out        <= bus.cache_inst;
                    inst_valid <= 1'b1;
                end else if (miss_count != '1) begin
                    miss_count <= miss_count + 1'b1;
                end
            end

            if (state == RESP) begin
                out        <= data_q;
                inst_valid <= 1'b1;
            end

            if (tmo_fire) begin
                out        <= '0;
                inst_valid <= 1'b1;
            end
        end
    end

endmodule
